// File: rtl/mips_instr_encoder_if.sv
// rtl/mips_instr_encoder_if.sv - Field-bundle input stream and imem write bus of the MIPS instruction encoder.
interface mips_instr_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_mnem;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              in_last;
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target, in_last, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target, in_last, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// rtl/mips_instr_encoder.sv - Packs decoded MIPS fields into words, buffers them and writes them into imem.
// Defining MIPS_ENC_CHECKSUM_EN adds a running XOR checksum of the written words.
module mips_instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 4,
  parameter int BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  mips_instr_encoder_if.slave bus,
  output logic [ADDR_W:0]     count,
  output logic                busy,
  output logic                done,
  output logic                err_bad_mnem,
  output logic                err_wrap
`ifdef MIPS_ENC_CHECKSUM_EN
  ,
  output logic [31:0]         checksum
`endif
);

  localparam int                PW        = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W:0]   COUNT_MAX = '1;
  localparam logic [PW:0]       FULL      = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]       occ_q, occ_d;
  logic              in_ready_q, in_ready_d, imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              busy_q, busy_d, done_q, done_d, bad_q, bad_d, wrap_q, wrap_d;
  logic              enc_legal;
  logic [31:0]       enc_word;
  logic              accept, push, pop;
`ifdef MIPS_ENC_CHECKSUM_EN
  logic [31:0]       csum_q, csum_d;
`endif

  always_comb begin
    enc_legal = 1'b1;
    enc_word  = '0;
    case (bus.in_mnem)
      5'd0:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'b100000};
      5'd1:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'b100001};
      5'd2:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'b100011};
      5'd3:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'b100100};
      5'd4:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'b100101};
      5'd5:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'b100110};
      5'd6:  enc_word = {6'b000000, bus.in_rs, 15'b0, 6'b001000};
      5'd7:  enc_word = {6'b000000, bus.in_rs, 5'b0, bus.in_rd, 5'b0, 6'b001001};
      5'd8:  enc_word = {6'b000010, bus.in_target};
      5'd9:  enc_word = {6'b000011, bus.in_target};
      5'd10: enc_word = {6'b001000, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd11: enc_word = {6'b001001, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd12: enc_word = {6'b001100, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd13: enc_word = {6'b001101, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd14: enc_word = {6'b001110, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd15: enc_word = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd16: enc_word = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd17: enc_word = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd18: enc_word = {6'b000101, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd19: enc_word = '0;
      default: enc_legal = 1'b0;
    endcase
  end

  assign accept = bus.in_valid & in_ready_q;
  assign push   = accept & enc_legal;
  assign pop    = imem_we_q & bus.imem_ready;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    occ_d    = occ_q + (PW+1)'(push) - (PW+1)'(pop);
    addr_d   = addr_q;
    count_d  = count_q;
    bad_d    = bad_q | (accept & ~enc_legal);
    wrap_d   = wrap_q;
`ifdef MIPS_ENC_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    if (pop) begin
      addr_d = addr_q + ADDR_W'(1);
      wrap_d = wrap_q | (addr_q == ADDR_LAST);
      if (count_q != COUNT_MAX) count_d = count_q + (ADDR_W+1)'(1);
`ifdef MIPS_ENC_CHECKSUM_EN
      csum_d = csum_q ^ wdata_q;
`endif
    end
    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        state_d = S_RUN;
        addr_d  = BASE;
        count_d = '0;
        bad_d   = 1'b0;
        wrap_d  = 1'b0;
`ifdef MIPS_ENC_CHECKSUM_EN
        csum_d  = '0;
`endif
      end
      S_RUN:   if (accept && bus.in_last) state_d = S_DRAIN;
      S_DRAIN: if (occ_q == '0) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_RUN) && (occ_d != FULL);
    imem_we_d  = (occ_d != '0);
    busy_d     = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d     = (state_d == S_DONE);
    // A word pushed into a FIFO that is empty after this pop becomes the new head directly.
    wdata_d    = wdata_q;
    if (imem_we_d) wdata_d = (occ_q == (PW+1)'(pop)) ? enc_word : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= enc_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      in_ready_q <= 1'b0;
      imem_we_q  <= 1'b0;
      addr_q     <= BASE;
      wdata_q    <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bad_q      <= 1'b0;
      wrap_q     <= 1'b0;
`ifdef MIPS_ENC_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      in_ready_q <= in_ready_d;
      imem_we_q  <= imem_we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bad_q      <= bad_d;
      wrap_q     <= wrap_d;
`ifdef MIPS_ENC_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign count          = count_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_bad_mnem   = bad_q;
  assign err_wrap       = wrap_q;
`ifdef MIPS_ENC_CHECKSUM_EN
  assign checksum       = csum_q;
`endif

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb/tb_mips_instr_encoder.sv - Self-checking bench for mips_instr_encoder with a behavioural scoreboard model.
module tb_mips_instr_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  always #5 clk = ~clk;

  mips_instr_encoder_if #(.ADDR_W(10)) b0 ();
  mips_instr_encoder_if #(.ADDR_W(2))  b1 ();

  logic [10:0] count0;
  logic [2:0]  count1;
  logic        busy0, done0, bad0, wrap0, busy1, done1, bad1, wrap1;
`ifdef MIPS_ENC_CHECKSUM_EN
  logic [31:0] csum0, csum1;
`endif

  mips_instr_encoder #(.ADDR_W(10), .DEPTH(4), .BASE_ADDR(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .bus(b0.slave), .count(count0),
    .busy(busy0), .done(done0), .err_bad_mnem(bad0), .err_wrap(wrap0)
`ifdef MIPS_ENC_CHECKSUM_EN
    , .checksum(csum0)
`endif
  );

  mips_instr_encoder #(.ADDR_W(2), .DEPTH(4), .BASE_ADDR(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bus(b1.slave), .count(count1),
    .busy(busy1), .done(done1), .err_bad_mnem(bad1), .err_wrap(wrap1)
`ifdef MIPS_ENC_CHECKSUM_EN
    , .checksum(csum1)
`endif
  );

  localparam int IDLE = 0, RUN = 1, DRAIN = 2, DONE = 3;

  int          n_chk = 0;
  int          n_err = 0;
  bit          mon_en = 0;
  int          rdy_mode = 0;
  logic [31:0] mq[$];
  int          m_phase = IDLE;
  int          m_addr = 0;
  int          m_count = 0;
  bit          m_bad = 0;
  bit          m_wrap = 0;
  logic [31:0] m_csum = '0;
  int          log_addr[$];
  logic [31:0] log_word[$];
  int          log1_addr[$];
  logic [31:0] log1_word[$];
  bit          stream_done = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit ref_enc(input int m, input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [31:0] rd, input logic [31:0] imm,
                                 input logic [31:0] tgt, output logic [31:0] w);
    logic [31:0] op, fn;
    bit rtype;
    rtype = 0;
    op = 0;
    fn = 0;
    w = 0;
    case (m)
      0: begin rtype = 1; fn = 32; end
      1: begin rtype = 1; fn = 33; end
      2: begin rtype = 1; fn = 35; end
      3: begin rtype = 1; fn = 36; end
      4: begin rtype = 1; fn = 37; end
      5: begin rtype = 1; fn = 38; end
      6: begin rtype = 1; fn = 8; rt = 0; rd = 0; end
      7: begin rtype = 1; fn = 9; rt = 0; end
      8:  return_j(2, tgt, w);
      9:  return_j(3, tgt, w);
      10: op = 8;
      11: op = 9;
      12: op = 12;
      13: op = 13;
      14: op = 14;
      15: op = 35;
      16: op = 43;
      17: op = 4;
      18: op = 5;
      19: ;
      default: return 0;
    endcase
    if (rtype) w = (rs << 21) + (rt << 16) + (rd << 11) + fn;
    else if (op != 0) w = (op << 26) + (rs << 21) + (rt << 16) + imm;
    return 1;
  endfunction

  function automatic void return_j(input logic [31:0] op, input logic [31:0] tgt, output logic [31:0] w);
    w = (op << 26) + tgt;
  endfunction

  // Scoreboard: check outputs against model state, then advance model to the coming rising edge.
  initial forever begin
    logic [31:0] w;
    int pre_size, pre_phase;
    bit legal;
    @(negedge clk);
    if (!rst_n) begin
      mq.delete();
      m_phase = IDLE; m_addr = 0; m_count = 0; m_bad = 0; m_wrap = 0; m_csum = '0;
    end else begin
      if (mon_en) begin
        chk("in_ready", b0.in_ready, (m_phase == RUN) && (mq.size() < 4));
        chk("imem_we", b0.imem_we, mq.size() != 0);
        chk("imem_addr", b0.imem_addr, m_addr);
        if (mq.size() != 0) chk("imem_wdata", b0.imem_wdata, mq[0]);
        chk("count", count0, m_count);
        chk("busy", busy0, (m_phase == RUN) || (m_phase == DRAIN));
        chk("done", done0, m_phase == DONE);
        chk("err_bad_mnem", bad0, m_bad);
        chk("err_wrap", wrap0, m_wrap);
`ifdef MIPS_ENC_CHECKSUM_EN
        chk("checksum", csum0, m_csum);
`endif
      end
      pre_size = mq.size();
      pre_phase = m_phase;
      if (b0.imem_we && b0.imem_ready) begin
        log_addr.push_back(int'(b0.imem_addr));
        log_word.push_back(b0.imem_wdata);
        if (mq.size() > 0) begin
          w = mq.pop_front();
          m_csum = m_csum ^ w;
        end
        if (m_addr == 1023) m_wrap = 1;
        m_addr = (m_addr + 1) % 1024;
        m_count++;
      end
      if (b0.in_valid && b0.in_ready) begin
        legal = ref_enc(int'(b0.in_mnem), 32'(b0.in_rs), 32'(b0.in_rt), 32'(b0.in_rd),
                        32'(b0.in_imm), 32'(b0.in_target), w);
        if (legal) mq.push_back(w);
        else m_bad = 1;
        if (b0.in_last && pre_phase == RUN) m_phase = DRAIN;
      end
      if (pre_phase == DRAIN && pre_size == 0) m_phase = DONE;
      if ((pre_phase == IDLE || pre_phase == DONE) && start0) begin
        m_phase = RUN; m_addr = 0; m_count = 0; m_bad = 0; m_wrap = 0; m_csum = '0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && b1.imem_we && b1.imem_ready) begin
      log1_addr.push_back(int'(b1.imem_addr));
      log1_word.push_back(b1.imem_wdata);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 0) b0.imem_ready = 1'b1;
    else if (rdy_mode == 1) b0.imem_ready = 1'b0;
    else b0.imem_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input int m, input int rs, input int rt, input int rd,
                      input int imm, input int tgt, input bit last);
    bit ok;
    @(posedge clk);
    #1;
    b0.in_valid = 1'b1; b0.in_mnem = 5'(m); b0.in_rs = 5'(rs); b0.in_rt = 5'(rt);
    b0.in_rd = 5'(rd); b0.in_imm = 16'(imm); b0.in_target = 26'(tgt); b0.in_last = last;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (b0.in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    b0.in_valid = 1'b0;
    b0.in_last = 1'b0;
  endtask

  task automatic send1(input int rs, input int rt, input int imm, input bit last);
    bit ok;
    @(posedge clk);
    #1;
    b1.in_valid = 1'b1; b1.in_mnem = 5'd16; b1.in_rs = 5'(rs); b1.in_rt = 5'(rt);
    b1.in_imm = 16'(imm); b1.in_last = last;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b1.in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("send1_timeout", 0, 1);
    @(posedge clk);
    #1;
    b1.in_valid = 1'b0;
    b1.in_last = 1'b0;
  endtask

  task automatic pulse_start0();
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
  endtask

  task automatic wait_done0();
    bit ok;
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done0) begin ok = 1; break; end
    end
    chk("done_timeout", ok, 1);
  endtask

  initial begin
    int base;
    logic [31:0] held, w;
    bit lg;
    b0.in_valid = 0; b0.in_mnem = 0; b0.in_rs = 0; b0.in_rt = 0; b0.in_rd = 0;
    b0.in_imm = 0; b0.in_target = 0; b0.in_last = 0; b0.imem_ready = 1;
    b1.in_valid = 0; b1.in_mnem = 0; b1.in_rs = 0; b1.in_rt = 0; b1.in_rd = 0;
    b1.in_imm = 0; b1.in_target = 0; b1.in_last = 0; b1.imem_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", b0.in_ready, 0);
    chk("rst_imem_we", b0.imem_we, 0);
    chk("rst_addr", b0.imem_addr, 0);
    chk("rst_wdata", b0.imem_wdata, 0);
    chk("rst_count", count0, 0);
    chk("rst_busy_done", {busy0, done0, bad0, wrap0}, 0);
    chk("rst_addr1", b1.imem_addr, 3);
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1;

    // ADDU then ORI
    base = log_word.size();
    pulse_start0();
    send(1, 1, 2, 3, 0, 0, 0);
    send(13, 4, 5, 0, 16'h00FF, 0, 1);
    wait_done0();
    chk("t1_word0", log_word[base], 32'h00221821);
    chk("t1_addr0", log_addr[base], 0);
    chk("t1_word1", log_word[base+1], 32'h348500FF);
    chk("t1_addr1", log_addr[base+1], 1);
    chk("t1_count", count0, 2);
    chk("t1_done", done0, 1);

    // JAL then JR
    base = log_word.size();
    pulse_start0();
    send(9, 0, 0, 0, 0, 26'h0000040, 0);
    send(6, 31, 7, 9, 0, 0, 1);
    wait_done0();
    chk("t2_word0", log_word[base], 32'h0C000040);
    chk("t2_word1", log_word[base+1], 32'h03E00008);
    chk("t2_addr1", log_addr[base+1], 1);

    // Backpressure: memory stalls while a stream of LW bundles arrives
    base = log_word.size();
    rdy_mode = 1;
    pulse_start0();
    stream_done = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(15, 2, i, 0, i * 4, 0, i == 5);
        stream_done = 1;
      end
    join_none
    repeat (8) @(negedge clk);
    held = b0.imem_wdata;
    chk("bp_head", held, 32'h8C400000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", b0.in_ready, 0);
      chk("bp_wdata_stable", b0.imem_wdata, held);
      chk("bp_addr_stable", b0.imem_addr, 0);
    end
    chk("bp_depth", mq.size(), 4);
    rdy_mode = 0;
    for (int i = 0; i < 400 && !stream_done; i++) @(negedge clk);
    chk("bp_stream_timeout", stream_done, 1);
    wait_done0();
    chk("bp_count", count0, 6);
    for (int i = 0; i < 6; i++) begin
      lg = ref_enc(15, 2, i, 0, i * 4, 0, w);
      chk("bp_order", log_word[base+i], w);
    end

    // Illegal mnemonic between NOPs
    base = log_word.size();
    pulse_start0();
    send(19, 3, 3, 3, 3, 3, 0);
    send(25, 1, 1, 1, 1, 1, 0);
    send(19, 0, 0, 0, 0, 0, 1);
    wait_done0();
    chk("bad_flag", bad0, 1);
    chk("bad_count", count0, 2);
    chk("bad_writes", log_word.size() - base, 2);

    // Randomised session with random memory backpressure
    rdy_mode = 2;
    pulse_start0();
    for (int i = 0; i < 40; i++)
      send($urandom_range(0, 23), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 65535), $urandom_range(0, 32'h3FFFFFF), i == 39);
    wait_done0();
    rdy_mode = 0;

    // Reset while draining with three words queued
    rdy_mode = 1;
    pulse_start0();
    send(0, 1, 2, 3, 0, 0, 0);
    send(0, 4, 5, 6, 0, 0, 0);
    send(0, 7, 8, 9, 0, 0, 1);
    @(negedge clk);
    chk("drain_we", b0.imem_we, 1);
    chk("drain_busy", busy0, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_we", b0.imem_we, 0);
    chk("rst_mid_state", {busy0, done0, b0.in_ready}, 0);
    chk("rst_mid_count", count0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rdy_mode = 0;
    base = log_word.size();
    pulse_start0();
    send(19, 0, 0, 0, 0, 0, 1);
    wait_done0();
    chk("post_rst_addr", log_addr[base], 0);
    chk("post_rst_count", count0, 1);

    // Narrow address space wraps from 3 to 0
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    send1(1, 2, 16'h0010, 0);
    send1(3, 4, 16'h0020, 1);
    for (int i = 0; i < 50 && !done1; i++) @(negedge clk);
    chk("wrap_done", done1, 1);
    chk("wrap_writes", log1_word.size(), 2);
    if (log1_word.size() == 2) begin
      chk("wrap_addr0", log1_addr[0], 3);
      chk("wrap_word0", log1_word[0], 32'hAC220010);
      chk("wrap_addr1", log1_addr[1], 0);
      chk("wrap_word1", log1_word[1], 32'hAC640020);
    end
    chk("wrap_flag", wrap1, 1);
    chk("wrap_count", count1, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #600000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
